// File: rtl/neander_pkg.sv
// Shared definitions for the Neander control unit: opcodes, ALU encodings,
// phase indices and the decoded instruction-class record.
package neander_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ALU_B   = 3'd0,
        ALU_ADD = 3'd1,
        ALU_OR  = 3'd2,
        ALU_AND = 3'd3,
        ALU_NOT = 3'd4
    } alu_op_e;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    // One-hot instruction class; alu covers LDA/ADD/OR/AND (operand fetch + AC load).
    typedef struct packed {
        logic st;
        logic alu;
        logic jmp;
        logic jn;
        logic jz;
        logic inv;
        logic hlt;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/neander_decode.sv
// Combinational opcode decoder: RI -> instruction class and ALU function.
module neander_decode
    import neander_pkg::*;
(
    input  logic [3:0] ri,
    output iclass_t    cls,
    output alu_op_e    fn
);

    always_comb begin
        cls = '0;
        fn  = ALU_B;
        case (ri)
            OP_STA: cls.st = 1'b1;
            OP_LDA: begin cls.alu = 1'b1; fn = ALU_B;   end
            OP_ADD: begin cls.alu = 1'b1; fn = ALU_ADD; end
            OP_OR:  begin cls.alu = 1'b1; fn = ALU_OR;  end
            OP_AND: begin cls.alu = 1'b1; fn = ALU_AND; end
            OP_NOT: begin cls.inv = 1'b1; fn = ALU_NOT; end
            OP_JMP: cls.jmp = 1'b1;
            OP_JN:  cls.jn  = 1'b1;
            OP_JZ:  cls.jz  = 1'b1;
            OP_HLT: cls.hlt = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/neander_control.sv
// Neander control unit: holds RI, N/Z, halted and phase_err, and turns the
// timing generator's one-hot phase into datapath strobes plus goto_t0.
module neander_control
    import neander_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NPHASE = 8
) (
    input  logic              ck,
    input  logic              nreset,
    input  logic [NPHASE-1:0] t,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] ac_next,
    output logic              goto_t0,
    output logic              sel,
    output logic              load_rem,
    output logic              load_rdm,
    output logic              load_pc,
    output logic              inc_pc,
    output logic              load_ac,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        alu_op,
    output logic              halted,
    output logic              phase_err
);

    logic [3:0] ri;
    logic       n_flag;
    logic       z_flag;
    logic       load_ri;
    logic       t_onehot;
    logic       active;
    logic       jtaken;
    iclass_t    cls;
    alu_op_e    fn;
    logic       unused_mem_low;

    assign unused_mem_low = ^mem_data[DATA_W-5:0];

    neander_decode u_decode (
        .ri  (ri),
        .cls (cls),
        .fn  (fn)
    );

    // Any abnormal condition (reset, halt, bad phase now or earlier) parks the
    // timing generator at T0 with every strobe low.
    assign t_onehot = $onehot(t);
    assign active   = nreset & ~halted & ~phase_err & t_onehot;
    assign jtaken   = cls.jmp | (cls.jn & n_flag) | (cls.jz & z_flag);

    always_comb begin
        goto_t0   = ~active;
        sel       = 1'b0;
        load_rem  = 1'b0;
        load_rdm  = 1'b0;
        load_pc   = 1'b0;
        inc_pc    = 1'b0;
        load_ac   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = ALU_B;
        load_ri   = 1'b0;
        if (active) begin
            if (t[T0]) begin
                load_rem = 1'b1;
            end else if (t[T1]) begin
                mem_read = 1'b1;
                inc_pc   = 1'b1;
            end else if (t[T2]) begin
                load_ri = 1'b1;
            end else if (t[T3]) begin
                if (cls.alu | cls.st | jtaken) begin
                    load_rem = 1'b1;
                end else if (cls.inv) begin
                    load_ac = 1'b1;
                    alu_op  = ALU_NOT;
                    goto_t0 = 1'b1;
                end else if (cls.jn | cls.jz) begin
                    inc_pc  = 1'b1;
                    goto_t0 = 1'b1;
                end else begin
                    goto_t0 = 1'b1;
                end
            end else if (t[T4]) begin
                if (cls.alu | cls.st) begin
                    mem_read = 1'b1;
                    inc_pc   = 1'b1;
                end else if (jtaken) begin
                    mem_read = 1'b1;
                end else begin
                    goto_t0 = 1'b1;
                end
            end else if (t[T5]) begin
                if (cls.alu | cls.st) begin
                    sel      = 1'b1;
                    load_rem = 1'b1;
                end else if (jtaken) begin
                    load_pc = 1'b1;
                    goto_t0 = 1'b1;
                end else begin
                    goto_t0 = 1'b1;
                end
            end else if (t[T6]) begin
                if (cls.alu)     mem_read = 1'b1;
                else if (cls.st) load_rdm = 1'b1;
                else             goto_t0  = 1'b1;
            end else begin
                // T7: last phase of every long instruction
                goto_t0 = 1'b1;
                if (cls.alu) begin
                    load_ac = 1'b1;
                    alu_op  = fn;
                end else if (cls.st) begin
                    mem_write = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge nreset) begin
        if (!nreset) begin
            ri        <= OP_NOP;
            n_flag    <= 1'b0;
            z_flag    <= 1'b1;
            halted    <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            if (!halted && !t_onehot)
                phase_err <= 1'b1;
            if (load_ri)
                ri <= mem_data[DATA_W-1 -: 4];
            if (load_ac) begin
                n_flag <= ac_next[DATA_W-1];
                z_flag <= (ac_next == '0);
            end
            if (active && t[T3] && cls.hlt)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neander_control.sv
// Self-checking bench for neander_control: the bench acts as timing generator
// and datapath, and checks every phase against a per-opcode step-table model.
module tb_neander_control;

    localparam logic [11:0] S_GO  = 12'h800;
    localparam logic [11:0] S_SEL = 12'h400;
    localparam logic [11:0] S_REM = 12'h200;
    localparam logic [11:0] S_RDM = 12'h100;
    localparam logic [11:0] S_PC  = 12'h080;
    localparam logic [11:0] S_INC = 12'h040;
    localparam logic [11:0] S_AC  = 12'h020;
    localparam logic [11:0] S_RD  = 12'h010;
    localparam logic [11:0] S_WR  = 12'h008;

    logic       ck = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] t = 8'h00;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] ac_next = 8'h00;
    logic       goto_t0, sel, load_rem, load_rdm, load_pc, inc_pc, load_ac;
    logic       mem_read, mem_write, halted, phase_err;
    logic [2:0] alu_op;
    logic [11:0] outv;

    int   n_cmp = 0;
    int   n_err = 0;
    logic m_n, m_z, m_halted;

    neander_control #(.DATA_W(8), .NPHASE(8)) dut (
        .ck(ck), .nreset(nreset), .t(t), .mem_data(mem_data), .ac_next(ac_next),
        .goto_t0(goto_t0), .sel(sel), .load_rem(load_rem), .load_rdm(load_rdm),
        .load_pc(load_pc), .inc_pc(inc_pc), .load_ac(load_ac), .mem_read(mem_read),
        .mem_write(mem_write), .alu_op(alu_op), .halted(halted), .phase_err(phase_err)
    );

    assign outv = {goto_t0, sel, load_rem, load_rdm, load_pc, inc_pc, load_ac,
                   mem_read, mem_write, alu_op};

    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Expected strobe word for an opcode at a phase, given the flags from before it.
    function automatic logic [11:0] exp_step(logic [3:0] op, int ph, logic n, logic z);
        if (ph == 0) return S_REM;
        if (ph == 1) return S_RD | S_INC;
        if (ph == 2) return 12'h000;
        case (op)
            4'h1: case (ph)
                    3: return S_REM;
                    4: return S_RD | S_INC;
                    5: return S_SEL | S_REM;
                    6: return S_RDM;
                    default: return S_WR | S_GO;
                  endcase
            4'h2, 4'h3, 4'h4, 4'h5: case (ph)
                    3: return S_REM;
                    4: return S_RD | S_INC;
                    5: return S_SEL | S_REM;
                    6: return S_RD;
                    default: return S_AC | S_GO | {9'd0, 3'(op - 4'h2)};
                  endcase
            4'h6: return S_AC | S_GO | 12'h004;
            4'h8, 4'h9, 4'hA: begin
                if (op == 4'h8 || (op == 4'h9 && n) || (op == 4'hA && z)) begin
                    case (ph)
                        3: return S_REM;
                        4: return S_RD;
                        default: return S_PC | S_GO;
                    endcase
                end
                return S_INC | S_GO;
            end
            default: return S_GO;
        endcase
    endfunction

    function automatic int exp_len(logic [3:0] op, logic n, logic z);
        for (int p = 0; p < 8; p++)
            if (exp_step(op, p, n, z) & S_GO) return p + 1;
        return 8;
    endfunction

    task automatic model_commit(input logic [3:0] op, input logic [7:0] acv);
        int len;
        logic n0, z0;
        n0 = m_n;
        z0 = m_z;
        len = exp_len(op, n0, z0);
        for (int p = 0; p < len; p++)
            if (exp_step(op, p, n0, z0) & S_AC) begin
                m_n = acv[7];
                m_z = (acv == 8'h00);
            end
        if (op == 4'hF) m_halted = 1'b1;
    endtask

    // Plays timing generator + datapath for one instruction; records outputs per phase.
    task automatic run_instr(input logic [3:0] op, input logic [7:0] acv,
                             output logic [7:0][11:0] obs, output int ncyc);
        logic [7:0] one;
        obs  = '0;
        ncyc = 0;
        for (int ph = 0; ph < 8; ph++) begin
            one = 8'h01;
            t = one << ph;
            mem_data = (ph == 2) ? {op, 4'($urandom)} : 8'($urandom);
            ac_next = acv;
            @(negedge ck);
            obs[ph] = outv;
            ncyc = ph + 1;
            @(posedge ck);
            #1;
            if (obs[ph][11]) break;
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        t = 8'h01;
        @(posedge ck);
        #1;
        nreset = 1'b1;
        m_n = 1'b0;
        m_z = 1'b1;
        m_halted = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0][11:0] obs;
        int ncyc, len;
        logic [3:0] ops [2];
        ops[0] = 4'h9;
        ops[1] = 4'hA;
        nreset = 1'b0;
        t = 8'h08;
        #3;
        @(negedge ck);
        n_cmp++; if (outv !== S_GO) begin n_err++; $display("FAIL reset_outputs got %h want %h", outv, S_GO); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (phase_err !== 1'b0) begin n_err++; $display("FAIL reset_phase_err got %b want 0", phase_err); end
        do_reset();
        // JN must fall through (N=0), JZ must be taken (Z=1) straight out of reset
        foreach (ops[i]) begin
            len = exp_len(ops[i], m_n, m_z);
            run_instr(ops[i], 8'h5A, obs, ncyc);
            for (int p = 0; p < len; p++) begin
                n_cmp++;
                if (obs[p] !== exp_step(ops[i], p, m_n, m_z)) begin
                    n_err++; $display("FAIL reset_flags op%h T%0d got %h want %h", ops[i], p, obs[p], exp_step(ops[i], p, m_n, m_z));
                end
            end
            n_cmp++; if (ncyc !== len) begin n_err++; $display("FAIL reset_flags_len op%h got %0d want %0d", ops[i], ncyc, len); end
            model_commit(ops[i], 8'h5A);
        end
    endtask

    // LDA 0 -> ADD 0x80 -> JN (taken) -> JZ (not taken) -> LDA 0 -> JZ (taken)
    task automatic test_add_jn_jz();
        logic [7:0][11:0] obs;
        int ncyc, len;
        logic [3:0] ops [6];
        logic [7:0] acs [6];
        ops = '{4'h2, 4'h3, 4'h9, 4'hA, 4'h2, 4'hA};
        acs = '{8'h00, 8'h80, 8'h11, 8'h22, 8'h00, 8'h33};
        do_reset();
        foreach (ops[i]) begin
            len = exp_len(ops[i], m_n, m_z);
            run_instr(ops[i], acs[i], obs, ncyc);
            for (int p = 0; p < len; p++) begin
                n_cmp++;
                if (obs[p] !== exp_step(ops[i], p, m_n, m_z)) begin
                    n_err++; $display("FAIL seq step%0d op%h T%0d got %h want %h", i, ops[i], p, obs[p], exp_step(ops[i], p, m_n, m_z));
                end
            end
            n_cmp++; if (ncyc !== len) begin n_err++; $display("FAIL seq_len step%0d got %0d want %0d", i, ncyc, len); end
            model_commit(ops[i], acs[i]);
        end
    endtask

    task automatic test_sta();
        logic [7:0][11:0] obs;
        int ncyc;
        run_instr(4'h1, 8'hFF, obs, ncyc);
        n_cmp++; if (ncyc !== 8) begin n_err++; $display("FAIL sta_len got %0d want 8", ncyc); end
        n_cmp++; if (obs[6] !== S_RDM) begin n_err++; $display("FAIL sta_T6 got %h want %h", obs[6], S_RDM); end
        n_cmp++; if (obs[7] !== (S_WR | S_GO)) begin n_err++; $display("FAIL sta_T7 got %h want %h", obs[7], S_WR | S_GO); end
        for (int p = 0; p < 8; p++) begin
            n_cmp++;
            if (obs[p] & S_AC) begin n_err++; $display("FAIL sta_no_load_ac T%0d got %h", p, obs[p]); end
        end
        model_commit(4'h1, 8'hFF);
    endtask

    task automatic test_random();
        logic [7:0][11:0] obs;
        int ncyc, len;
        logic [3:0] op;
        logic [7:0] acv;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 14));
            case ($urandom_range(0, 3))
                0: acv = 8'h00;
                1: acv = 8'h80 | 8'($urandom);
                default: acv = 8'($urandom);
            endcase
            len = exp_len(op, m_n, m_z);
            run_instr(op, acv, obs, ncyc);
            for (int p = 0; p < len; p++) begin
                n_cmp++;
                if (obs[p] !== exp_step(op, p, m_n, m_z)) begin
                    n_err++; $display("FAIL rand k%0d op%h T%0d got %h want %h", k, op, p, obs[p], exp_step(op, p, m_n, m_z));
                end
            end
            n_cmp++; if (ncyc !== len) begin n_err++; $display("FAIL rand_len k%0d op%h got %0d want %0d", k, op, ncyc, len); end
            model_commit(op, acv);
        end
    endtask

    task automatic test_hlt();
        logic [7:0][11:0] obs;
        int ncyc;
        logic [7:0] one;
        run_instr(4'hF, 8'h00, obs, ncyc);
        model_commit(4'hF, 8'h00);
        n_cmp++; if (ncyc !== 4 || obs[3] !== S_GO) begin n_err++; $display("FAIL hlt_T3 got %h len %0d want %h len 4", obs[3], ncyc, S_GO); end
        n_cmp++; if (halted !== m_halted) begin n_err++; $display("FAIL hlt_halted got %b want %b", halted, m_halted); end
        for (int c = 0; c < 10; c++) begin
            one = 8'h01;
            t = one << $urandom_range(0, 7);
            mem_data = 8'($urandom);
            ac_next = 8'($urandom);
            @(negedge ck);
            n_cmp++; if (outv !== S_GO) begin n_err++; $display("FAIL hlt_idle c%0d got %h want %h", c, outv, S_GO); end
            @(posedge ck);
            #1;
        end
        do_reset();
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_reset got %b want 0", halted); end
    endtask

    task automatic test_phase_err();
        t = 8'b0000_0110;
        @(negedge ck);
        n_cmp++; if (outv !== S_GO) begin n_err++; $display("FAIL perr_bad_cycle got %h want %h", outv, S_GO); end
        @(posedge ck);
        #1;
        for (int c = 0; c < 4; c++) begin
            t = (c == 0) ? 8'h01 : 8'h02;
            @(negedge ck);
            n_cmp++; if (phase_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky c%0d got %b want 1", c, phase_err); end
            n_cmp++; if (outv !== S_GO) begin n_err++; $display("FAIL perr_strobes c%0d got %h want %h", c, outv, S_GO); end
            @(posedge ck);
            #1;
        end
        do_reset();
        n_cmp++; if (phase_err !== 1'b0) begin n_err++; $display("FAIL perr_reset got %b want 0", phase_err); end
    endtask

    task automatic test_reset_mid_sta();
        logic [7:0] one;
        logic [7:0][11:0] obs;
        int ncyc, len;
        for (int ph = 0; ph < 7; ph++) begin
            one = 8'h01;
            t = one << ph;
            mem_data = (ph == 2) ? 8'h1C : 8'($urandom);
            if (ph < 6) begin
                @(posedge ck);
                #1;
            end
        end
        #1;
        n_cmp++; if (outv !== S_RDM) begin n_err++; $display("FAIL midsta_T6 got %h want %h", outv, S_RDM); end
        nreset = 1'b0;
        #1;
        n_cmp++; if (outv !== S_GO) begin n_err++; $display("FAIL midsta_reset got %h want %h", outv, S_GO); end
        @(posedge ck);
        #1;
        t = 8'h80;
        @(negedge ck);
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL midsta_mem_write got %b want 0", mem_write); end
        do_reset();
        len = exp_len(4'hA, m_n, m_z);
        run_instr(4'hA, 8'h00, obs, ncyc);
        n_cmp++; if (ncyc !== len) begin n_err++; $display("FAIL midsta_jz_len got %0d want %0d", ncyc, len); end
        model_commit(4'hA, 8'h00);
    endtask

    initial begin
        m_n = 1'b0;
        m_z = 1'b1;
        m_halted = 1'b0;
        test_reset();
        test_add_jn_jz();
        test_sta();
        test_random();
        test_hlt();
        test_phase_err();
        test_reset_mid_sta();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
